// File: rtl/cnt_ctrl_pkg.sv
// Shared types and defaults for the run/pause/clear counter controller.
// State encoding is fixed because it is visible on the state output port.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         DB_CYCLES_DEF = 4;
  localparam int         TICK_DIV_DEF  = 10;
  localparam logic [3:0] STOP_VAL_DEF  = 4'd9;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnt_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-sample debouncer and
// rising-edge press pulse, with presses ignored until a released level is seen.
module btn_debounce
  import cnt_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int            CW      = cnt_width(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    vld_q;
  logic          smp_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;
  logic          level_q;
  logic          level_prev_q;
  logic          armed_q;

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: all flops here are reset; there is no memory array that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // NOTE: cnt_d and accept get defaults first so no path through the block infers a latch.
  always_comb begin
    cnt_d  = CW'(1);
    accept = 1'b0;
    if (sync2_q == smp_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    accept = vld_q[1] && (cnt_d == CNT_MAX);
  end

  // vld_q[1] marks sync2_q as holding a real sample rather than its reset value,
  // so a button held through reset cannot be mistaken for a released one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q        <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      if (vld_q[1]) begin
        smp_q <= sync2_q;
        cnt_q <= cnt_d;
        if (accept) begin
          level_q <= sync2_q;
          if (!sync2_q) begin
            armed_q <= 1'b1;
          end
        end
      end
    end
  end

  assign press = level_q & ~level_prev_q & armed_q;

endmodule

// File: rtl/cnt_ctrl.sv
// Run/pause/clear controller producing count-enable and clear pulses for a 4-bit counter.
// Define CNT_CTRL_AUTOSTOP_EN to stop in DONE once the counter reaches STOP_VAL.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int         DB_CYCLES = DB_CYCLES_DEF,
  parameter int         TICK_DIV  = TICK_DIV_DEF,
  parameter logic [3:0] STOP_VAL  = STOP_VAL_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic [3:0] cnt_val,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [1:0] state,
  output logic       running
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

  logic          start_press;
  logic          clr_press;
  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic          presc_tc;
  logic          autostop;
  logic          cnt_clr_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_start),
    .press (start_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn_clr),
    .press (clr_press)
  );

  assign presc_tc = (presc_q == PRESC_TC);

`ifdef CNT_CTRL_AUTOSTOP_EN
  assign autostop = cnt_en && (cnt_val == STOP_VAL - 4'd1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cnt_val, STOP_VAL};
  assign autostop   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clr outranks every other event; a terminal tick outranks a pause request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_press) state_d = RUN;
      end
      RUN: begin
        if (clr_press)        state_d = IDLE;
        else if (autostop)    state_d = DONE;
        else if (start_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_press)        state_d = IDLE;
        else if (start_press) state_d = RUN;
      end
      DONE: begin
        if (clr_press || start_press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running   = (state_q == RUN);
    cnt_en    = (state_q == RUN) && presc_tc;
    cnt_clr_d = (state_d == IDLE) && (state_q != IDLE);
  end

  // The prescaler only advances while staying in RUN, so a pause resumes at the
  // exact phase it left and leaving for IDLE/DONE lands on zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= cnt_clr_d;
      if ((state_d == IDLE) || (state_d == DONE)) begin
        presc_q <= '0;
      end else if ((state_q == RUN) && (state_d == RUN)) begin
        presc_q <= presc_tc ? '0 : presc_q + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed bench for cnt_ctrl with DB_CYCLES=4, TICK_DIV=10, STOP_VAL=9.
// Expected values come from hand-computed cycle tables below.
module tb_cnt_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_clr;
  logic [3:0] cnt_val;
  logic       cnt_en;
  logic       cnt_clr;
  logic [1:0] state;
  logic       running;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cnt_ctrl #(
    .DB_CYCLES (4),
    .TICK_DIV  (10),
    .STOP_VAL  (4'd9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .cnt_val   (cnt_val),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .state     (state),
    .running   (running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input int t, input int a, input int b);
    return (t >= a) && (t <= b);
  endfunction

  // Main scenario schedule, t = cycle index from the first start press.
  task automatic drive(input int t);
    btn_start = in_win(t, 0, 7) || in_win(t, 46, 53) || in_win(t, 66, 73) ||
                in_win(t, 92, 99) || in_win(t, 110, 117);
    btn_clr   = in_win(t, 92, 99) || in_win(t, 140, 147);
    cnt_val   = (t >= 100) ? 4'd8 : 4'd0;
  endtask

  function automatic logic [1:0] exp_state(input int t);
    if (t < 7)   return S_IDLE;
    if (t < 53)  return S_RUN;
    if (t < 73)  return S_PAUSE;
    if (t < 99)  return S_RUN;
    if (t < 117) return S_IDLE;
`ifdef CNT_CTRL_AUTOSTOP_EN
    if (t < 127) return S_RUN;
    if (t < 147) return S_DONE;
`else
    if (t < 147) return S_RUN;
`endif
    return S_IDLE;
  endfunction

  function automatic logic exp_en(input int t);
    if (t == 16 || t == 26 || t == 36 || t == 46) return 1'b1;
    if (t == 77 || t == 87 || t == 97 || t == 126) return 1'b1;
`ifndef CNT_CTRL_AUTOSTOP_EN
    if (t == 136 || t == 146) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic exp_clr(input int t);
    return (t == 99) || (t == 147);
  endfunction

  initial begin
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    cnt_val   = 4'd0;

    // Reset asserted with both buttons held; outputs must clear at once.
    #2;
    reset     = 1'b0;
    btn_start = 1'b1;
    btn_clr   = 1'b1;
    #1;
    check("rst_async_state", state, S_IDLE);
    check("rst_async_running", running, 1'b0);
    check("rst_async_cnt_en", cnt_en, 1'b0);
    check("rst_async_cnt_clr", cnt_clr, 1'b0);
    repeat (3) step();
    check("rst_state", state, S_IDLE);
    check("rst_running", running, 1'b0);
    check("rst_cnt_en", cnt_en, 1'b0);
    check("rst_cnt_clr", cnt_clr, 1'b0);

    // Buttons held through release must not register.
    reset = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("held_state@%0d", i), state, S_IDLE);
      check($sformatf("held_cnt_clr@%0d", i), cnt_clr, 1'b0);
    end
    btn_start = 1'b0;
    btn_clr   = 1'b0;
    repeat (12) step();

    // A 3-cycle glitch is shorter than the debounce window.
    btn_start = 1'b1;
    repeat (3) step();
    btn_start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("glitch_state@%0d", i), state, S_IDLE);
      check($sformatf("glitch_cnt_en@%0d", i), cnt_en, 1'b0);
    end
    repeat (5) step();

    // Start / pause / resume / simultaneous press / auto-stop / clear.
    drive(0);
    for (int t = 1; t <= 150; t++) begin
      step();
      check($sformatf("state@%0d", t), state, exp_state(t));
      check($sformatf("running@%0d", t), running, exp_state(t) == S_RUN);
      check($sformatf("cnt_en@%0d", t), cnt_en, exp_en(t));
      check($sformatf("cnt_clr@%0d", t), cnt_clr, exp_clr(t));
      drive(t);
    end

    // Reset in the middle of a RUN, right on a count-enable cycle.
    cnt_val   = 4'd0;
    btn_clr   = 1'b0;
    btn_start = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (s == 8) btn_start = 1'b0;
    end
    check("midrun_state", state, S_RUN);
    check("midrun_cnt_en", cnt_en, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_rst_state", state, S_IDLE);
    check("midrun_rst_running", running, 1'b0);
    check("midrun_rst_cnt_en", cnt_en, 1'b0);
    check("midrun_rst_cnt_clr", cnt_clr, 1'b0);
    repeat (2) begin
      step();
      check("midrun_rst_hold_cnt_clr", cnt_clr, 1'b0);
    end
    reset = 1'b1;
    repeat (12) step();

    // Prescaler progress must be gone: first enable again 9 cycles into RUN.
    btn_start = 1'b1;
    for (int u = 1; u <= 20; u++) begin
      step();
      check($sformatf("post_rst_state@%0d", u), state, (u < 7) ? S_IDLE : S_RUN);
      check($sformatf("post_rst_cnt_en@%0d", u), cnt_en, u == 16);
      check($sformatf("post_rst_cnt_clr@%0d", u), cnt_clr, 1'b0);
      if (u == 7) btn_start = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
